// File: rtl/dht_transaction_ctrl.sv
// DHT11/DHT22 single-wire transaction controller.
// Drives the host start pulse on the open-drain line and detects the sensor
// response. It then decodes the 40-bit frame MSB-first, verifies the
// checksum, and reports humidity/temperature with done/valid/error status.
module dht_transaction_ctrl #(
    parameter int CLK_FREQ_HZ   = 1_000_000,
    parameter int START_LOW_US  = 18000,
    parameter int BIT_THRESH_US = 50,
    parameter int TIMEOUT_US    = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    inout  wire         dht_data,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        err_timeout,
    output logic        err_checksum,
    output logic [15:0] humidity,
    output logic [15:0] temperature
);

    localparam int TICKS_RAW = CLK_FREQ_HZ / 1_000_000;
    localparam int TICKS_US  = (TICKS_RAW < 1) ? 1 : TICKS_RAW;
    localparam int START_N   = START_LOW_US * TICKS_US;
    localparam int TO_N      = TIMEOUT_US * TICKS_US;
    localparam int TH_N      = BIT_THRESH_US * TICKS_US;
    localparam int MAX_A     = (START_N > TO_N) ? START_N : TO_N;
    localparam int MAX_N     = (MAX_A > TH_N) ? MAX_A : TH_N;
    localparam int CW        = $clog2(MAX_N + 1);

    localparam logic [CW-1:0] START_LAST = CW'(START_N - 1);
    localparam logic [CW-1:0] TO_CNT     = CW'(TO_N);
    localparam logic [CW-1:0] TH_CNT     = CW'(TH_N);

    typedef enum logic [2:0] {
        IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [5:0]    idx;
    logic [39:0]   shreg;
    logic          sync1, din_s, din_q;
    logic          rise, fall, tmo;
    logic          cnt_clr, shift_en, idx_clr, finish, timeout_hit;
    logic [7:0]    sum;

    // Open-drain pad: only ever pulled low, otherwise released.
    assign dht_data = (state == START_LOW) ? 1'b0 : 1'bz;
    assign busy     = (state != IDLE);

    assign rise = din_s & ~din_q;
    assign fall = ~din_s & din_q;
    assign tmo  = (cnt == TO_CNT);
    assign sum  = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

    // Two-flop synchroniser plus edge-reference register; idle line reads high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            din_s <= 1'b1;
            din_q <= 1'b1;
        end else begin
            sync1 <= dht_data;
            din_s <= sync1;
            din_q <= din_s;
        end
    end

    // Next-state logic; the counter clears on every transition, which also
    // covers every accepted edge since each accepted edge moves the FSM.
    always_comb begin
        state_n     = state;
        cnt_clr     = 1'b0;
        shift_en    = 1'b0;
        idx_clr     = 1'b0;
        finish      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE:      if (start) state_n = START_LOW;
            START_LOW: if (cnt == START_LAST) state_n = RELEASE;
            RELEASE: begin
                if (fall) state_n = RESP_LOW;
                else if (tmo) begin state_n = IDLE; timeout_hit = 1'b1; end
            end
            RESP_LOW: begin
                if (rise) state_n = RESP_HIGH;
                else if (tmo) begin state_n = IDLE; timeout_hit = 1'b1; end
            end
            RESP_HIGH: begin
                if (fall) begin state_n = BIT_LOW; idx_clr = 1'b1; end
                else if (tmo) begin state_n = IDLE; timeout_hit = 1'b1; end
            end
            BIT_LOW: begin
                if (rise) state_n = BIT_HIGH;
                else if (tmo) begin state_n = IDLE; timeout_hit = 1'b1; end
            end
            BIT_HIGH: begin
                if (fall) begin
                    shift_en = 1'b1;
                    cnt_clr  = 1'b1;
                    state_n  = (idx == 6'd39) ? CHECK : BIT_LOW;
                end else if (tmo) begin
                    state_n = IDLE; timeout_hit = 1'b1;
                end
            end
            CHECK: begin
                state_n = IDLE;
                finish  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (state_n != state) cnt_clr = 1'b1;
    end

    // State, counter, frame capture and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            done         <= 1'b0;
            valid        <= 1'b0;
            err_timeout  <= 1'b0;
            err_checksum <= 1'b0;
            humidity     <= '0;
            temperature  <= '0;
        end else begin
            state <= state_n;
            cnt   <= (cnt_clr || state == IDLE) ? '0 : cnt + CW'(1);
            done  <= finish | timeout_hit;
            if (idx_clr) idx <= '0;
            else if (shift_en) idx <= idx + 6'd1;
            if (shift_en) shreg <= {shreg[38:0], (cnt > TH_CNT)};
            if (timeout_hit) begin
                valid        <= 1'b0;
                err_timeout  <= 1'b1;
                err_checksum <= 1'b0;
            end
            if (finish) begin
                err_timeout <= 1'b0;
                if (sum == shreg[7:0]) begin
                    valid        <= 1'b1;
                    err_checksum <= 1'b0;
                    humidity     <= shreg[39:24];
                    temperature  <= shreg[23:8];
                end else begin
                    valid        <= 1'b0;
                    err_checksum <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dht_transaction_ctrl.sv
// Bench for dht_transaction_ctrl: two instances share one pulled-up line
// (full 18 ms start pulse and 1 ms DHT22 variant) driven by a sensor model.
module tb_dht_transaction_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b, sens_low, sens_bit_hi;
    wire  dht_line;
    logic busy_a, done_a, valid_a, eto_a, ecs_a;
    logic busy_b, done_b, valid_b, eto_b, ecs_b;
    logic [15:0] hum_a, temp_a, hum_b, temp_b;
    int cyc = 0, errors = 0, checks = 0, done_cnt_b = 0, last_rise_cyc = 0;

    pullup (dht_line);
    assign dht_line = sens_low ? 1'b0 : 1'bz;

    dht_transaction_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dht_data(dht_line),
        .busy(busy_a), .done(done_a), .valid(valid_a), .err_timeout(eto_a),
        .err_checksum(ecs_a), .humidity(hum_a), .temperature(temp_a));

    dht_transaction_ctrl #(.START_LOW_US(1000)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dht_data(dht_line),
        .busy(busy_b), .done(done_b), .valid(valid_b), .err_timeout(eto_b),
        .err_checksum(ecs_b), .humidity(hum_b), .temperature(temp_b));

    // Free-running cycle count and done-pulse tally for the short instance.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;

    typedef struct {
        logic [39:0] frame;
        logic        exp_valid;
        logic [15:0] exp_hum;
        logic [15:0] exp_temp;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Sensor: wait for host start pulse and release, answer 80/80 us, then
    // send nbits bits (0 = 50 low + 26 high, 1 = 50 low + 70 high) and a
    // trailing 50 us low before releasing the line for good.
    task automatic sensor(input logic [39:0] frame, input int nbits, input bit respond);
        int n;
        n = 0;
        while (dht_line !== 1'b0 && n < 30000) begin @(negedge clk); n++; end
        if (n >= 30000) begin fail_to("sensor_start_seen"); return; end
        n = 0;
        while (dht_line !== 1'b1 && n < 30000) begin @(negedge clk); n++; end
        if (n >= 30000) begin fail_to("sensor_release_seen"); return; end
        if (!respond) return;
        repeat (30) @(negedge clk);
        sens_low = 1'b1; repeat (80) @(negedge clk);
        sens_low = 1'b0; repeat (80) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sens_low = 1'b1; repeat (50) @(negedge clk);
            sens_low = 1'b0; sens_bit_hi = 1'b1;
            repeat (frame[39-i] ? 70 : 26) @(negedge clk);
            sens_bit_hi = 1'b0;
        end
        sens_low = 1'b1; repeat (50) @(negedge clk);
        sens_low = 1'b0;
        last_rise_cyc = cyc;
        repeat (5) @(negedge clk);
    endtask

    // One transaction on the short instance; optional extra start pulses while busy.
    task automatic run_b(input logic [39:0] frame, input int nbits, input bit respond,
                         input bit extra, output int lat, output int done_cyc);
        lat = 0;
        done_cyc = 0;
        fork
            sensor(frame, nbits, respond);
            begin
                int n;
                @(negedge clk); start_b = 1'b1;
                @(negedge clk); start_b = 1'b0;
                n = 1;
                while (done_b !== 1'b1 && n < 40000) begin
                    @(negedge clk); n++;
                    start_b = extra && (n == 100 || n == 2000 || n == 3000);
                end
                start_b = 1'b0;
                if (n >= 40000) fail_to("done_b_wait");
                lat = n;
                done_cyc = cyc;
            end
        join
        repeat (20) @(negedge clk);
    endtask

    // Reference: checksum is the byte sum mod 256; a bad frame keeps old data.
    function automatic vec_t model_vec(input logic [39:0] frame, input logic [15:0] ph,
                                       input logic [15:0] pt);
        vec_t v;
        int s;
        s = (int'(frame[39:32]) + int'(frame[31:24]) + int'(frame[23:16]) + int'(frame[15:8])) % 256;
        v.frame     = frame;
        v.exp_valid = (s == int'(frame[7:0]));
        v.exp_hum   = v.exp_valid ? frame[39:24] : ph;
        v.exp_temp  = v.exp_valid ? frame[23:8]  : pt;
        return v;
    endfunction

    initial begin
        int lat, dc, c0, low, n;
        logic [39:0] f;
        logic [7:0]  b[4];
        int s;

        vecs[0] = '{40'h37_00_19_00_50, 1'b1, 16'h3700, 16'h1900};
        vecs[1] = '{40'h37_00_19_00_51, 1'b0, 16'h3700, 16'h1900};
        vecs[2] = '{40'h02_8C_01_5F_EE, 1'b1, 16'h028C, 16'h015F};
        for (int i = 3; i < NV; i++) begin
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 255));
            s = (int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3])) % 256;
            if ($urandom_range(0, 1) == 0) s = (s + int'($urandom_range(1, 255))) % 256;
            f = {b[0], b[1], b[2], b[3], 8'(s)};
            vecs[i] = model_vec(f, vecs[i-1].exp_hum, vecs[i-1].exp_temp);
        end

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sens_low = 1'b0; sens_bit_hi = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_done_b", done_b, 0);
        chk("rst_flags_b", {valid_b, eto_b, ecs_b}, 0);
        chk("rst_data_b", {hum_b, temp_b}, 0);
        chk("rst_line_released", dht_line, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Full-length start pulse on the default instance.
        fork
            sensor(40'h37_00_19_00_50, 40, 1'b1);
            begin
                @(negedge clk); start_a = 1'b1;
                @(negedge clk); start_a = 1'b0;
                chk("a_busy_after_start", busy_a, 1);
                low = 0;
                while (dht_line === 1'b0 && low < 30000) begin low++; @(negedge clk); end
                chk("a_start_low_cycles", low, 18000);
                n = 0;
                while (done_a !== 1'b1 && n < 30000) begin @(negedge clk); n++; end
                if (n >= 30000) fail_to("done_a_wait");
                @(negedge clk);
                chk("a_done_one_cycle", done_a, 0);
            end
        join
        chk("a_valid", valid_a, 1);
        chk("a_errors", {eto_a, ecs_a}, 0);
        chk("a_humidity", hum_a, 16'h3700);
        chk("a_temperature", temp_a, 16'h1900);

        // Table of frames on the 1 ms instance; row 3 also gets start pulses while busy.
        for (int i = 0; i < NV; i++) begin
            c0 = done_cnt_b;
            run_b(vecs[i].frame, 40, 1'b1, i == 3, lat, dc);
            chk($sformatf("v%0d_done_count", i), 40'(done_cnt_b - c0), 1);
            chk($sformatf("v%0d_valid", i), valid_b, vecs[i].exp_valid);
            chk($sformatf("v%0d_err_checksum", i), ecs_b, !vecs[i].exp_valid);
            chk($sformatf("v%0d_err_timeout", i), eto_b, 0);
            chk($sformatf("v%0d_humidity", i), hum_b, vecs[i].exp_hum);
            chk($sformatf("v%0d_temperature", i), temp_b, vecs[i].exp_temp);
            chk($sformatf("v%0d_busy_after", i), busy_b, 0);
        end

        // Reset in the middle of a bit-high phase.
        c0 = done_cnt_b;
        fork
            sensor(40'h37_00_19_00_50, 40, 1'b1);
            begin
                @(negedge clk); start_b = 1'b1;
                @(negedge clk); start_b = 1'b0;
                n = 0;
                while (sens_bit_hi !== 1'b1 && n < 30000) begin @(negedge clk); n++; end
                if (n >= 30000) fail_to("bit_high_wait");
                repeat (10) @(negedge clk);
                chk("mid_busy_before_rst", busy_b, 1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("mid_rst_busy", busy_b, 0);
                chk("mid_rst_done", done_b, 0);
                chk("mid_rst_flags", {valid_b, eto_b, ecs_b}, 0);
                chk("mid_rst_data", {hum_b, temp_b}, 0);
                chk("mid_rst_line", dht_line, 1);
            end
        join
        repeat (20) @(negedge clk);
        chk("mid_rst_no_done", 40'(done_cnt_b - c0), 0);
        chk("mid_rst_idle_after_frame", busy_b, 0);

        // Fresh transaction after the reset completes normally.
        c0 = done_cnt_b;
        run_b(40'h02_8C_01_5F_EE, 40, 1'b1, 1'b0, lat, dc);
        chk("post_rst_done_count", 40'(done_cnt_b - c0), 1);
        chk("post_rst_valid", valid_b, 1);
        chk("post_rst_humidity", hum_b, 16'h028C);
        chk("post_rst_temperature", temp_b, 16'h015F);

        // No sensor answer: 1000 low + 201 cycles in RELEASE, done on the next edge.
        c0 = done_cnt_b;
        run_b(40'h0, 0, 1'b0, 1'b0, lat, dc);
        chk("noresp_latency", lat, 1000 + 200 + 2);
        chk("noresp_err_timeout", eto_b, 1);
        chk("noresp_valid", {valid_b, ecs_b}, 0);
        chk("noresp_humidity_held", hum_b, 16'h028C);
        chk("noresp_done_count", 40'(done_cnt_b - c0), 1);

        // Sensor stalls high after 20 bits: 3 sync cycles + 201 counting.
        c0 = done_cnt_b;
        run_b(40'hA5_5A_C3_3C_00, 20, 1'b1, 1'b0, lat, dc);
        chk("stall_timeout_delay", 40'(dc - last_rise_cyc), 204);
        chk("stall_err_timeout", eto_b, 1);
        chk("stall_busy_after", busy_b, 0);
        chk("stall_done_count", 40'(done_cnt_b - c0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
